// File: rtl/mcu_data_mem.sv
// Parametrised single-port data memory with phase-gated access,
// read-modify-write bit ops and a hardware clear sequencer.
module mcu_data_mem #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                SIZE_CNT = 3,
    parameter int                CNT_CLK  = 2,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE_CNT:0] cnt_clk,
    input  logic              Clr,
    input  logic              WR,
    input  logic [1:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Write_data,
    output logic [DATA_W-1:0] Dout,
    output logic              Rd_valid,
    output logic              Busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [SIZE_CNT:0] ACC_PH = (SIZE_CNT + 1)'(CNT_CLK + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEARING
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              clr_we;
    logic              acc;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rmw;
    logic [DATA_W-1:0] mem [DEPTH];

    assign Busy  = (state == S_CLEARING);
    assign acc   = (cnt_clk == ACC_PH) && !Busy && !Clr;
    // rst can land while the sequencer is idle, so writes need their own gate
    assign wr_en = acc && WR && !rst;
    assign rd_en = acc && !WR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEARING;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Clr) begin
                    state_nxt = S_CLEARING;
                    ptr_nxt   = '0;
                end
            end
            S_CLEARING: begin
                clr_we = !rst;
                if (Clr) begin
                    ptr_nxt = '0;
                end else if (ptr == LAST) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        rmw = Write_data;
        unique case (Op)
            2'b00: rmw = Write_data;
            2'b01: rmw = mem[Addr] | Write_data;
            2'b10: rmw = mem[Addr] & ~Write_data;
            2'b11: rmw = mem[Addr] ^ Write_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr[ADDR_W-1:0]] <= CLR_VAL;
        end else if (wr_en) begin
            mem[Addr] <= rmw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Dout     <= '0;
            Rd_valid <= 1'b0;
        end else begin
            Rd_valid <= rd_en;
            if (rd_en) begin
                Dout <= mem[Addr];
            end
        end
    end
endmodule

// File: tb/tb_mcu_data_mem.sv
// Scoreboard bench for mcu_data_mem: an 8x16 and a 16x64 instance
// share one stimulus stream and are checked against array models.
module tb_mcu_data_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cnt_clk = '0;
    logic        clr = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  op = '0;
    logic [5:0]  addr = '0;
    logic [15:0] wd = '0;
    logic [7:0]  dout0;
    logic [15:0] dout1;
    logic        rv0, rv1, busy0, busy1;
    logic        sb0, sb1;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    logic [15:0] mm [2][64];
    bit          bm [2];
    int          ix [2];
    logic [15:0] ld [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    always #5 clk = ~clk;

    mcu_data_mem #(
        .DATA_W(8), .ADDR_W(4), .SIZE_CNT(3), .CNT_CLK(2), .CLR_VAL(8'hA5)
    ) dut0 (
        .clk(clk), .rst(rst), .cnt_clk(cnt_clk), .Clr(clr), .WR(wr),
        .Op(op), .Addr(addr[3:0]), .Write_data(wd[7:0]),
        .Dout(dout0), .Rd_valid(rv0), .Busy(busy0)
    );

    mcu_data_mem #(
        .DATA_W(16), .ADDR_W(6), .SIZE_CNT(3), .CNT_CLK(2), .CLR_VAL(16'h5A5A)
    ) dut1 (
        .clk(clk), .rst(rst), .cnt_clk(cnt_clk), .Clr(clr), .WR(wr),
        .Op(op), .Addr(addr), .Write_data(wd),
        .Dout(dout1), .Rd_valid(rv1), .Busy(busy1)
    );

    function automatic logic [15:0] f_op(input logic [1:0] o,
                                         input logic [15:0] m,
                                         input logic [15:0] x);
        case (o)
            2'd0:    return x;
            2'd1:    return m | x;
            2'd2:    return m & ~x;
            default: return m ^ x;
        endcase
    endfunction

    // reference model: one call per rising edge, using the inputs just applied
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            int          dep;
            int          am;
            logic [15:0] wm;
            logic [15:0] cv;
            bit          a;
            dep = (d == 0) ? 16 : 64;
            wm  = (d == 0) ? 16'h00FF : 16'hFFFF;
            cv  = (d == 0) ? 16'h00A5 : 16'h5A5A;
            am  = int'(addr) % dep;
            if (rst) begin
                bm[d] = 1'b1;
                ix[d] = 0;
                ld[d] = '0;
            end else begin
                a = (cnt_clk == 4'd3) && !bm[d] && !clr;
                if (bm[d]) begin
                    mm[d][ix[d]] = cv;
                    if (clr) ix[d] = 0;
                    else if (ix[d] == dep - 1) bm[d] = 1'b0;
                    else ix[d] = ix[d] + 1;
                end else if (clr) begin
                    bm[d] = 1'b1;
                    ix[d] = 0;
                end
                if (a && wr) mm[d][am] = f_op(op, mm[d][am], wd) & wm;
                if (a && !wr) begin
                    if (d == 0) q0.push_back(mm[d][am]);
                    else q1.push_back(mm[d][am]);
                end
            end
        end
    endtask

    task automatic cmp(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    task automatic check(input int d, input logic rv,
                         input logic [15:0] dv, input logic bz);
        logic [15:0] e;
        int          qs;
        qs = (d == 0) ? q0.size() : q1.size();
        n_cmp++;
        if (bz !== bm[d]) begin
            n_bad++;
            $display("FAIL busy%0d: got %b, required %b", d, bz, bm[d]);
        end
        n_cmp++;
        if (rv === 1'b1) begin
            if (qs == 0) begin
                n_bad++;
                $display("FAIL rd_valid%0d: spurious pulse, Dout %h", d, dv);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                ld[d] = e;
                if (dv !== e) begin
                    n_bad++;
                    $display("FAIL rd%0d: Dout %h, required %h", d, dv, e);
                end
            end
        end else if (rv !== 1'b0 || qs != 0) begin
            n_bad++;
            $display("FAIL rd_valid%0d: got %b, required 1", d, rv);
            if (d == 0 && qs != 0) void'(q0.pop_front());
            if (d == 1 && qs != 0) void'(q1.pop_front());
        end else if (dv !== ld[d]) begin
            n_bad++;
            $display("FAIL hold%0d: Dout %h, required %h", d, dv, ld[d]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check(0, rv0, {8'h00, dout0}, busy0);
            check(1, rv1, dout1, busy1);
        end
    end

    task automatic cyc(input bit r, input bit c, input logic [3:0] ph,
                       input bit w, input logic [1:0] o,
                       input logic [5:0] a, input logic [15:0] x);
        @(negedge clk);
        rst = r; clr = c; cnt_clk = ph; wr = w; op = o; addr = a; wd = x;
        @(posedge clk);
        step();
        #1;
        sb0 = busy0;
        sb1 = busy1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 6'd0, 16'd0);
    endtask

    task automatic acc(input bit w, input logic [1:0] o,
                       input logic [5:0] a, input logic [15:0] x);
        cyc(1'b0, 1'b0, 4'd1, w, o, a, x);
        cyc(1'b0, 1'b0, 4'd3, w, o, a, x);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bm[0] || bm[1]) && n < 300) begin
            idle();
            n++;
        end
        cmp("wait_idle_timeout", int'(bm[0] || bm[1]), 0);
    endtask

    task automatic count_busy(input string nm);
        int n0 = -1;
        int n1 = -1;
        int n = 0;
        while ((n0 < 0 || n1 < 0) && n < 300) begin
            idle();
            n++;
            if (!sb0 && n0 < 0) n0 = n;
            if (!sb1 && n1 < 0) n1 = n;
        end
        cmp({nm, "_busy16"}, n0, 16);
        cmp({nm, "_busy64"}, n1, 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bm[0] = 1'b1; bm[1] = 1'b1;
        ix[0] = 0;    ix[1] = 0;
        ld[0] = '0;   ld[1] = '0;
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 6'd0, 16'd0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 4'd3, 1'b1, 2'd0, 6'd1, 16'h1234);
        count_busy("reset");

        for (int i = 0; i < 16; i++) acc(1'b0, 2'd0, 6'(i), 16'd0);

        for (int p = 0; p < 3; p++)
            cyc(1'b0, 1'b0, 4'(p), 1'b1, 2'd0, 6'd5, 16'h003C);
        acc(1'b0, 2'd0, 6'd5, 16'd0);
        acc(1'b1, 2'd0, 6'd5, 16'h003C);
        acc(1'b0, 2'd0, 6'd5, 16'd0);

        acc(1'b1, 2'd0, 6'd7, 16'h000F);
        acc(1'b1, 2'd1, 6'd7, 16'h00F0);
        acc(1'b0, 2'd0, 6'd7, 16'd0);
        acc(1'b1, 2'd2, 6'd7, 16'h0081);
        acc(1'b0, 2'd0, 6'd7, 16'd0);
        acc(1'b1, 2'd3, 6'd7, 16'h00FF);
        acc(1'b0, 2'd0, 6'd7, 16'd0);

        acc(1'b1, 2'd0, 6'd2, 16'h0011);
        acc(1'b0, 2'd0, 6'd2, 16'd0);
        wait_idle();
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'd0, 6'd0, 16'd0);
        cyc(1'b0, 1'b0, 4'd3, 1'b1, 2'd0, 6'd2, 16'h0022);
        cyc(1'b0, 1'b0, 4'd3, 1'b0, 2'd0, 6'd2, 16'd0);
        wait_idle();
        acc(1'b0, 2'd0, 6'd2, 16'd0);

        acc(1'b1, 2'd0, 6'd9, 16'h0077);
        cyc(1'b0, 1'b1, 4'd3, 1'b1, 2'd0, 6'd9, 16'h0066);
        wait_idle();
        acc(1'b0, 2'd0, 6'd9, 16'd0);
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 2'd0, 6'd9, 16'd0);
        repeat (9) idle();
        cyc(1'b1, 1'b0, 4'd3, 1'b1, 2'd0, 6'd4, 16'h4444);
        count_busy("rst_mid_clear");

        wait_idle();
        acc(1'b1, 2'd0, 6'd63, 16'hBEEF);
        acc(1'b0, 2'd0, 6'd63, 16'd0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] ph;
            ph = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'($urandom_range(0, 7));
            cyc(1'b0, ($urandom_range(0, 59) == 0), ph,
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                6'($urandom_range(0, 63)), 16'($urandom));
        end
        wait_idle();
        for (int i = 0; i < 64; i++) acc(1'b0, 2'd0, 6'(i), 16'd0);
        idle();
        cmp("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mcu_data_mem.md
# mcu_data_mem

Parametrised single-port data memory for the 8-bit MCU datapath, replacing the fixed 16×8 register file. Accesses stay gated by the shared phase counter `cnt_clk`. The block adds configurable width and depth, and read-modify-write bit operations (set, clear, toggle). A hardware clear sequencer initialises every location after reset or on request, and a busy/valid handshake lets the control unit know when the memory is usable and when read data has landed.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `ADDR_W`, default 4: address width; depth `DEPTH = 2**ADDR_W`.
- `SIZE_CNT`, default 3: MSB index of `cnt_clk`, which is `SIZE_CNT+1` bits wide.
- `CNT_CLK`, default 2: access phase; an access fires when `cnt_clk == CNT_CLK+1`.
  - Constraint: `CNT_CLK+1 <= 2**(SIZE_CNT+1)-1`.
- `CLR_VAL`, default 0: value written to every location by the clear sequencer.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `cnt_clk`  in  SIZE_CNT+1  phase counter from the control unit.
- `Clr`  in  1  clear request, sampled each cycle.
- `WR`  in  1  1 = write / RMW access, 0 = read access.
- `Op`  in  2  write mode:
  - 00 plain write.
  - 01 set bits (`mem | Write_data`).
  - 10 clear bits (`mem & ~Write_data`).
  - 11 toggle (`mem ^ Write_data`).
- `Addr`  in  ADDR_W  word address.
- `Write_data`  in  DATA_W  write data or bit mask.
- `Dout`  out  DATA_W  registered read data.
- `Rd_valid`  out  1  one-cycle pulse; `Dout` was updated at this edge.
- `Busy`  out  1  clear sequencer active; accesses are ignored.

## Operation
- Access strobe: `acc = (cnt_clk == CNT_CLK+1) && !Busy && !Clr`.
- Write, when `acc && WR`: `mem[Addr] <= f(Op, mem[Addr], Write_data)`.
  - Read and write of the same word complete in the same cycle; no extra latency.
  - `Dout` holds its value; `Rd_valid` = 0.
- Read, when `acc && !WR`: `Dout <= mem[Addr]`, and `Rd_valid <= 1` for exactly one cycle.
  - `Op` is ignored.
- No strobe: memory and `Dout` hold; `Rd_valid <= 0`.
- Clear sequencer states:
  - IDLE: if `Clr`, go to CLEARING with `ptr <= 0`.
  - CLEARING: write `mem[ptr] <= CLR_VAL` and increment `ptr`.
    - At `ptr == DEPTH-1`, write the last word and go to IDLE.
    - If `Clr` is seen again in CLEARING, `ptr` restarts at 0.
  - `Busy` = 1 exactly while the state is CLEARING.
- Reset: while `rst`=1, the state is CLEARING, `ptr`=0, `Dout`=0, `Rd_valid`=0, `Busy`=1. No memory writes occur during `rst`.
  - The reset-triggered clear begins on the first edge after `rst` falls.
- Memory array contents are undefined until the first clear completes; they are not reset directly.

## Timing
- Clear after `rst` release:
  - Writes addresses 0..DEPTH-1 on edges 1..DEPTH.
  - `Busy` falls at edge DEPTH, so `Busy` is high for exactly DEPTH cycles after release.
- Clear from `Clr` at edge N (IDLE): `Busy` = 1 from edge N to edge N+DEPTH; address 0 is written at edge N+1.
- Read latency: 1 edge. `Dout` and `Rd_valid` are valid in the cycle after the strobe edge. `Dout` holds until the next read strobe.
- Back-to-back accesses are limited only by the `cnt_clk` period; one access per strobe edge.
- Simultaneous events:
  - `Clr` together with a strobe: `Clr` wins and the access is dropped.
  - Strobe while `Busy`: dropped silently; no `Rd_valid`.
  - `rst` mid-clear or mid-access: `rst` wins; the sequencer restarts from 0 after release.
- Address wrap: `ptr` is ADDR_W+1 bits wide internally, so termination at DEPTH-1 is exact.
- `Addr` always indexes inside the array; there is no out-of-range case.

## Test plan
- Reset/clear (DEPTH=16, CLR_VAL=0xA5):
  - Pulse `rst` for 2 cycles, then count `Busy` → high for exactly 16 cycles.
  - Reads of addresses 0..15 then return 0xA5, each with a single-cycle `Rd_valid`.
- Phase gating (CNT_CLK=2):
  - Write 0x3C to addr 5 with `cnt_clk`=0..2 → no change.
  - With `cnt_clk`=3 → read of addr 5 returns 0x3C one cycle later.
- RMW ops, starting from addr 7 = 0x0F:
  - Op=01, mask 0xF0 → 0xFF.
  - Op=10, mask 0x81 → 0x7E.
  - Op=11, mask 0xFF → 0x81.
- Busy blocking:
  - Assert `Clr` with addr 2 = 0x11 → addr 2 becomes CLR_VAL.
  - A write of 0x22 during `Busy` is dropped; a read during `Busy` gives no `Rd_valid` and `Dout` unchanged.
- Collisions:
  - `Clr` asserted on a write strobe edge → write dropped, `Busy` rises.
  - `rst` asserted at `ptr`=9 mid-clear → after release, clear restarts at 0 and lasts 16 cycles.
- Width parameters: DATA_W=16, ADDR_W=6.
  - Clear spans 64 cycles.
  - Write 0xBEEF to addr 63 and read back 0xBEEF.
